// File: rtl/sexpr_mon_pkg.sv
// Shared limits and the saturating-add helper for the implication monitor.
// Pure declarations; no clocked logic lives here.
package sexpr_mon_pkg;

    localparam int MAX_DLY = 31;
    localparam int MAX_NCH = 16;

    // The counter stops at lim instead of wrapping, so a stuck property stays visible.
    function automatic logic [31:0] sat_add(input logic [31:0] cur,
                                            input logic [31:0] inc,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, cur} + {1'b0, inc};
        return (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

endpackage

// File: rtl/sexpr_impl_chan.sv
// One channel of "ante |-> ##[DLY_MIN:DLY_MAX] cons", tracking one attempt per start cycle.
// Pass/fail pulses and counters update one cycle after the deciding sample; no backpressure.
module sexpr_impl_chan
    import sexpr_mon_pkg::*;
#(
    parameter int DLY_MIN  = 1,
    parameter int DLY_MAX  = 3,
    parameter int CNT_W    = 16,
    parameter bit INV_CONS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ante_i,
    input  logic             cons_i,
    input  logic             disable_i,
    input  logic             clr_i,
    output logic             pass_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             busy_o
);

    // Keep one storage bit even when the window collapses to the antecedent cycle.
    localparam int          PW      = (DLY_MAX > 0) ? DLY_MAX : 1;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [PW-1:0]    r_pend;
    logic [PW:0]      w_live;
    logic [PW:0]      w_hit;
    logic             w_ce;
    logic             w_miss;
    logic [5:0]       w_hit_cnt;
    logic             r_pass;
    logic             r_fail;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;

    always_comb begin
        w_ce      = cons_i ^ INV_CONS;
        w_live    = {r_pend, ante_i};
        w_hit     = '0;
        w_hit_cnt = '0;
        if (disable_i) begin
            w_live = '0;
        end
        for (int k = DLY_MIN; k <= DLY_MAX; k++) begin
            w_hit[k]  = w_live[k] & w_ce;
            w_hit_cnt = w_hit_cnt + {5'd0, w_hit[k]};
        end
        w_miss = w_live[DLY_MAX] & ~w_ce;
    end

    generate
        if (DLY_MAX > 0) begin : g_pend
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pend <= '0;
                end else begin
                    r_pend <= w_live[PW-1:0] & ~w_hit[PW-1:0];
                end
            end
        end else begin : g_nopend
            assign r_pend = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_pass <= |w_hit;
            r_fail <= w_miss;
            if (clr_i) begin
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
            end else begin
                r_pass_cnt <= CNT_W'(sat_add(32'(r_pass_cnt), 32'(w_hit_cnt), CNT_MAX));
                r_fail_cnt <= CNT_W'(sat_add(32'(r_fail_cnt), 32'(w_miss), CNT_MAX));
            end
        end
    end

    assign pass_o     = r_pass;
    assign fail_o     = r_fail;
    assign pass_cnt_o = r_pass_cnt;
    assign fail_cnt_o = r_fail_cnt;
    assign busy_o     = |r_pend;

endmodule

// File: rtl/sexpr_impl_monitor.sv
// NCH independent implication monitors with packed per-channel counters.
// One-cycle latency from the deciding sample to pulses/counters; no backpressure.
module sexpr_impl_monitor
    import sexpr_mon_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DLY_MIN  = 1,
    parameter int DLY_MAX  = 3,
    parameter int CNT_W    = 16,
    parameter int INV_CONS = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       ante_i,
    input  logic [NCH-1:0]       cons_i,
    input  logic [NCH-1:0]       disable_i,
    input  logic                 clr_i,
    output logic [NCH-1:0]       pass_o,
    output logic [NCH-1:0]       fail_o,
    output logic [NCH*CNT_W-1:0] pass_cnt_o,
    output logic [NCH*CNT_W-1:0] fail_cnt_o,
    output logic [NCH-1:0]       busy_o
);

    generate
        if (NCH < 1 || NCH > MAX_NCH || DLY_MIN < 0 || DLY_MIN > MAX_DLY ||
            DLY_MAX < DLY_MIN || DLY_MAX > MAX_DLY || CNT_W < 4 || CNT_W > 32 ||
            (INV_CONS != 0 && INV_CONS != 1)) begin : g_param_err
            $fatal(1, "sexpr_impl_monitor: illegal parameter combination");
        end
    endgenerate

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        sexpr_impl_chan #(
            .DLY_MIN  (DLY_MIN),
            .DLY_MAX  (DLY_MAX),
            .CNT_W    (CNT_W),
            .INV_CONS (INV_CONS != 0)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .ante_i     (ante_i[c]),
            .cons_i     (cons_i[c]),
            .disable_i  (disable_i[c]),
            .clr_i      (clr_i),
            .pass_o     (pass_o[c]),
            .fail_o     (fail_o[c]),
            .pass_cnt_o (pass_cnt_o[c*CNT_W +: CNT_W]),
            .fail_cnt_o (fail_cnt_o[c*CNT_W +: CNT_W]),
            .busy_o     (busy_o[c])
        );
    end

endmodule

// File: tb/tb_sexpr_impl_monitor.sv
// Directed bench for sexpr_impl_monitor: default window, inverted consequent,
// overlapping (m=0) window and a narrow saturating counter configuration.
module tb_sexpr_impl_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Default configuration: NCH=4, m=1, n=3, CNT_W=16
    logic [3:0]  d_ante = '0, d_cons = '0, d_dis = '0;
    logic        d_clr = 1'b0;
    logic [3:0]  d_pass, d_fail, d_busy;
    logic [63:0] d_pcnt, d_fcnt;

    // Inverted consequent, m=n=1, single channel
    logic        i_ante = 1'b0, i_cons = 1'b0, i_dis = 1'b0, i_clr = 1'b0;
    logic        i_pass, i_fail, i_busy;
    logic [15:0] i_pcnt, i_fcnt;

    // Saturation: CNT_W=4, m=1, n=3
    logic        s_ante = 1'b0, s_cons = 1'b0, s_dis = 1'b0, s_clr = 1'b0;
    logic        s_pass, s_fail, s_busy;
    logic [3:0]  s_pcnt, s_fcnt;

    // Overlapping implication: m=0, n=2
    logic        o_ante = 1'b0, o_cons = 1'b0, o_dis = 1'b0, o_clr = 1'b0;
    logic        o_pass, o_fail, o_busy;
    logic [15:0] o_pcnt, o_fcnt;

    sexpr_impl_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .ante_i(d_ante), .cons_i(d_cons), .disable_i(d_dis),
        .clr_i(d_clr), .pass_o(d_pass), .fail_o(d_fail), .pass_cnt_o(d_pcnt),
        .fail_cnt_o(d_fcnt), .busy_o(d_busy)
    );

    sexpr_impl_monitor #(.NCH(1), .DLY_MIN(1), .DLY_MAX(1), .INV_CONS(1)) u_inv (
        .clk(clk), .rst_n(rst_n), .ante_i(i_ante), .cons_i(i_cons), .disable_i(i_dis),
        .clr_i(i_clr), .pass_o(i_pass), .fail_o(i_fail), .pass_cnt_o(i_pcnt),
        .fail_cnt_o(i_fcnt), .busy_o(i_busy)
    );

    sexpr_impl_monitor #(.NCH(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .ante_i(s_ante), .cons_i(s_cons), .disable_i(s_dis),
        .clr_i(s_clr), .pass_o(s_pass), .fail_o(s_fail), .pass_cnt_o(s_pcnt),
        .fail_cnt_o(s_fcnt), .busy_o(s_busy)
    );

    sexpr_impl_monitor #(.NCH(1), .DLY_MIN(0), .DLY_MAX(2)) u_ovl (
        .clk(clk), .rst_n(rst_n), .ante_i(o_ante), .cons_i(o_cons), .disable_i(o_dis),
        .clr_i(o_clr), .pass_o(o_pass), .fail_o(o_fail), .pass_cnt_o(o_pcnt),
        .fail_cnt_o(o_fcnt), .busy_o(o_busy)
    );

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_dut();
        d_ante = '0; d_cons = '0; d_dis = '0;
        d_clr = 1'b1;
        step();
        d_clr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({d_pass, d_fail, d_busy, d_pcnt, d_fcnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut got pass=%b fail=%b busy=%b pcnt=%h fcnt=%h exp all 0",
                     d_pass, d_fail, d_busy, d_pcnt, d_fcnt);
        end
        n_tests++;
        if ({i_pass, i_fail, i_busy, i_pcnt, i_fcnt, s_pcnt, o_pcnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_other got i=%b%b%b %h %h s=%h o=%h exp all 0",
                     i_pass, i_fail, i_busy, i_pcnt, i_fcnt, s_pcnt, o_pcnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_pass_window();
        d_ante = 4'b0001;
        step();
        n_tests++;
        if (d_busy !== 4'b0001 || d_pass !== 4'b0000) begin
            n_fail++;
            $display("FAIL win_t0 got busy=%b pass=%b exp busy=0001 pass=0000", d_busy, d_pass);
        end
        d_ante = '0;
        step();
        d_cons = 4'b0001;
        step();
        n_tests++;
        if (d_pass !== 4'b0001 || d_fail !== 4'b0000 || d_busy !== 4'b0000) begin
            n_fail++;
            $display("FAIL win_pass got pass=%b fail=%b busy=%b exp 0001 0000 0000",
                     d_pass, d_fail, d_busy);
        end
        d_cons = '0;
        step();
        n_tests++;
        if (d_pass !== 4'b0000 || d_pcnt[15:0] !== 16'd1 || d_fcnt[15:0] !== 16'd0) begin
            n_fail++;
            $display("FAIL win_cnt got pass=%b pcnt=%0d fcnt=%0d exp 0000 1 0",
                     d_pass, d_pcnt[15:0], d_fcnt[15:0]);
        end
        clr_dut();
    endtask

    task automatic test_fail_window();
        d_ante = 4'b0001;
        step();
        d_ante = '0;
        step();
        step();
        n_tests++;
        if (d_fail !== 4'b0000) begin
            n_fail++;
            $display("FAIL fail_early got fail=%b exp 0000", d_fail);
        end
        step();
        n_tests++;
        if (d_fail !== 4'b0001 || d_pass !== 4'b0000 || d_fcnt[15:0] !== 16'd1) begin
            n_fail++;
            $display("FAIL fail_pulse got fail=%b pass=%b fcnt=%0d exp 0001 0000 1",
                     d_fail, d_pass, d_fcnt[15:0]);
        end
        step();
        n_tests++;
        if (d_fail !== 4'b0000 || d_fcnt[15:0] !== 16'd1 || d_busy !== 4'b0000) begin
            n_fail++;
            $display("FAIL fail_once got fail=%b fcnt=%0d busy=%b exp 0000 1 0000",
                     d_fail, d_fcnt[15:0], d_busy);
        end
        clr_dut();
    endtask

    task automatic test_back_to_back();
        d_ante = 4'b0001;
        step();
        step();
        step();
        d_ante = '0;
        d_cons = 4'b0001;
        step();
        n_tests++;
        if (d_pass !== 4'b0001 || d_pcnt[15:0] !== 16'd3 || d_fcnt[15:0] !== 16'd0) begin
            n_fail++;
            $display("FAIL b2b got pass=%b pcnt=%0d fcnt=%0d exp 0001 3 0",
                     d_pass, d_pcnt[15:0], d_fcnt[15:0]);
        end
        d_cons = '0;
        step();
        n_tests++;
        if (d_busy !== 4'b0000 || d_pass !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_idle got busy=%b pass=%b exp 0000 0000", d_busy, d_pass);
        end
    endtask

    task automatic test_async_reset();
        d_ante = 4'b0010;
        step();
        d_ante = '0;
        n_tests++;
        if (d_busy !== 4'b0010) begin
            n_fail++;
            $display("FAIL ar_busy got busy=%b exp 0010", d_busy);
        end
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (d_busy !== 4'b0000 || d_pcnt !== '0) begin
            n_fail++;
            $display("FAIL ar_async got busy=%b pcnt=%h exp 0000 0", d_busy, d_pcnt);
        end
        d_cons = 4'b0000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            n_tests++;
            if (d_pass !== 4'b0000 || d_fail !== 4'b0000) begin
                n_fail++;
                $display("FAIL ar_discard cyc%0d got pass=%b fail=%b exp 0000 0000",
                         t, d_pass, d_fail);
            end
        end
    endtask

    task automatic test_multi_channel();
        d_ante = 4'b0110;
        step();
        d_ante = '0;
        d_cons = 4'b0010;
        step();
        n_tests++;
        if (d_pass !== 4'b0010 || d_busy !== 4'b0100) begin
            n_fail++;
            $display("FAIL mc_pass got pass=%b busy=%b exp 0010 0100", d_pass, d_busy);
        end
        d_cons = '0;
        step();
        step();
        n_tests++;
        if (d_fail !== 4'b0100 || d_pass !== 4'b0000) begin
            n_fail++;
            $display("FAIL mc_fail got fail=%b pass=%b exp 0100 0000", d_fail, d_pass);
        end
        n_tests++;
        if (d_pcnt !== 64'h0000_0000_0001_0000 || d_fcnt !== 64'h0000_0001_0000_0000) begin
            n_fail++;
            $display("FAIL mc_cnt got pcnt=%h fcnt=%h exp 0000000000010000 0000000100000000",
                     d_pcnt, d_fcnt);
        end
        clr_dut();
    endtask

    task automatic test_disable();
        d_ante = 4'b0001;
        step();
        d_ante = '0;
        d_dis = 4'b0001;
        step();
        n_tests++;
        if (d_busy !== 4'b0000) begin
            n_fail++;
            $display("FAIL dis_busy got busy=%b exp 0000", d_busy);
        end
        d_dis = '0;
        d_cons = 4'b0001;
        step();
        d_cons = '0;
        step();
        step();
        n_tests++;
        if (d_pass !== 4'b0000 || d_fail !== 4'b0000 || d_pcnt !== '0 || d_fcnt !== '0) begin
            n_fail++;
            $display("FAIL dis_quiet got pass=%b fail=%b pcnt=%h fcnt=%h exp all 0",
                     d_pass, d_fail, d_pcnt, d_fcnt);
        end
        d_ante = 4'b0001;
        d_dis = 4'b0001;
        step();
        d_ante = '0;
        d_dis = '0;
        n_tests++;
        if (d_busy !== 4'b0000) begin
            n_fail++;
            $display("FAIL dis_ante got busy=%b exp 0000", d_busy);
        end
    endtask

    task automatic test_inv_cons();
        logic [4:0] cons_seq;
        logic [4:0] exp_pass;
        logic [4:0] exp_fail;
        cons_seq = 5'b10101;
        exp_pass = 5'b01010;
        exp_fail = 5'b10100;
        i_ante = 1'b1;
        for (int t = 0; t < 5; t++) begin
            i_cons = cons_seq[t];
            step();
            n_tests++;
            if (i_pass !== exp_pass[t] || i_fail !== exp_fail[t]) begin
                n_fail++;
                $display("FAIL inv_t%0d got pass=%b fail=%b exp %b %b",
                         t, i_pass, i_fail, exp_pass[t], exp_fail[t]);
            end
        end
        n_tests++;
        if (i_pcnt !== 16'd2 || i_fcnt !== 16'd2) begin
            n_fail++;
            $display("FAIL inv_cnt got pcnt=%0d fcnt=%0d exp 2 2", i_pcnt, i_fcnt);
        end
        i_ante = 1'b0;
        i_dis = 1'b1;
        step();
        i_dis = 1'b0;
    endtask

    task automatic test_saturate_clear();
        s_ante = 1'b1;
        s_cons = 1'b1;
        for (int t = 0; t < 3; t++) step();
        n_tests++;
        if (s_pcnt !== 4'd2) begin
            n_fail++;
            $display("FAIL sat_ramp got pcnt=%0d exp 2", s_pcnt);
        end
        for (int t = 0; t < 20; t++) step();
        n_tests++;
        if (s_pcnt !== 4'd15 || s_pass !== 1'b1 || s_fcnt !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_hold got pcnt=%0d pass=%b fcnt=%0d exp 15 1 0",
                     s_pcnt, s_pass, s_fcnt);
        end
        s_clr = 1'b1;
        step();
        n_tests++;
        if (s_pcnt !== 4'd0 || s_pass !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_clr got pcnt=%0d pass=%b exp 0 1", s_pcnt, s_pass);
        end
        s_clr = 1'b0;
        step();
        n_tests++;
        if (s_pcnt !== 4'd1) begin
            n_fail++;
            $display("FAIL sat_after_clr got pcnt=%0d exp 1", s_pcnt);
        end
        s_ante = 1'b0;
        s_cons = 1'b0;
    endtask

    task automatic test_overlap();
        o_ante = 1'b1;
        o_cons = 1'b1;
        step();
        n_tests++;
        if (o_pass !== 1'b1 || o_pcnt !== 16'd1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovl_same got pass=%b pcnt=%0d busy=%b exp 1 1 0",
                     o_pass, o_pcnt, o_busy);
        end
        o_cons = 1'b0;
        step();
        n_tests++;
        if (o_pass !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovl_wait got pass=%b busy=%b exp 0 1", o_pass, o_busy);
        end
        o_ante = 1'b0;
        o_cons = 1'b1;
        step();
        n_tests++;
        if (o_pass !== 1'b1 || o_pcnt !== 16'd2 || o_busy !== 1'b0 || o_fcnt !== 16'd0) begin
            n_fail++;
            $display("FAIL ovl_late got pass=%b pcnt=%0d busy=%b fcnt=%0d exp 1 2 0 0",
                     o_pass, o_pcnt, o_busy, o_fcnt);
        end
        o_cons = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass_window();
        test_fail_window();
        test_back_to_back();
        test_async_reset();
        test_multi_channel();
        test_disable();
        test_inv_cons();
        test_saturate_clear();
        test_overlap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sexpr_impl_monitor.md
SEXPR_IMPL_MONITOR -- requirements
Module: sexpr_impl_monitor

Interface
REQ-001 Parameter NCH, default 4, number of independent monitor channels (1..16).
REQ-002 Parameter DLY_MIN, default 1, lower bound m of consequent window "ante |-> ##[m:n] cons" (0..31).
REQ-003 Parameter DLY_MAX, default 3, upper bound n (DLY_MIN..31).
REQ-004 Parameter CNT_W, default 16, width of pass/fail counters (4..32).
REQ-005 Parameter INV_CONS, default 0; 1 = consequent is "not cons".
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 ante_i  input  NCH  per-channel antecedent sample.
REQ-009 cons_i  input  NCH  per-channel consequent sample.
REQ-010 disable_i  input  NCH  per-channel "disable iff": aborts all attempts.
REQ-011 clr_i  input  1  synchronous clear of all counters.
REQ-012 pass_o  output  NCH  one-cycle pulse: >=1 attempt passed.
REQ-013 fail_o  output  NCH  one-cycle pulse: one attempt failed.
REQ-014 pass_cnt_o  output  NCH*CNT_W  saturating per-channel pass count.
REQ-015 fail_cnt_o  output  NCH*CNT_W  saturating per-channel fail count.
REQ-016 busy_o  output  NCH  channel has >=1 pending attempt.

Function
REQ-017 Each channel keeps pending vector pend_q[DLY_MAX-1:0]; bit k = attempt started k+1 cycles ago, not yet satisfied.
REQ-018 Live vector per cycle: L[0]=ante_i, L[k]=pend_q[k-1] for 1<=k<=DLY_MAX; ce = cons_i XOR INV_CONS.
REQ-019 hit[k] = L[k] & ce for DLY_MIN<=k<=DLY_MAX, else 0; miss = L[DLY_MAX] & ~ce.
REQ-020 Next pend_q[k] = L[k] & ~hit[k] for 0<=k<DLY_MAX; overlapping attempts tracked independently, one per start cycle.
REQ-021 DLY_MIN=0 means overlapping implication: consequent in the antecedent cycle passes immediately.
REQ-022 pass_o registered: high cycle t+1 iff any hit at t; fail_o high cycle t+1 iff miss at t; latency exactly 1 cycle.
REQ-023 pass_cnt adds popcount(hit) (multiple attempts may pass same cycle); fail_cnt adds miss; both saturate at all-ones.
REQ-024 disable_i high at t: L forced to zero for that channel, pend_q cleared, no hit/miss, ante_i ignored, no pulses at t+1.
REQ-025 clr_i high: all counters zero next cycle; clr_i wins over simultaneous increment; pend_q and pulses unaffected.
REQ-026 busy_o = OR of pend_q (registered state only).
REQ-027 DLY_MIN=DLY_MAX=0 degenerates to same-cycle check; pend_q zero width, busy_o constant 0.

Reset
REQ-028 rst_n low: pend_q, pass_o, fail_o, pass_cnt_o, fail_cnt_o, busy_o all zero immediately, independent of clk.
REQ-029 Reset mid-attempt discards pending attempts; no pass/fail reported for them after release.
REQ-030 First sample after reset release is the first rising edge with rst_n high.

Structure
REQ-031 Package sexpr_mon_pkg holds max-delay constant (31), max NCH (16) and the counter-saturation function.
REQ-032 One sub-module sexpr_impl_chan implements one channel; top generates NCH instances and packs outputs.
REQ-033 Parameter legality (DLY_MAX>=DLY_MIN, ranges above) checked at elaboration with fatal error.

Verification
REQ-034 m=1,n=3: ante at t0, cons at t2 only -> pass_o at t3, pass_cnt=1, fail_cnt=0.
REQ-035 m=1,n=3: ante at t0, cons never -> fail_o at t4 only, fail_cnt=1.
REQ-036 m=1,n=3: ante at t0,t1,t2, cons at t3 -> pass_o at t4, pass_cnt=3 (single-cycle +3).
REQ-037 INV_CONS=1,m=n=1: ante every cycle, cons toggling 1,0,1,0 -> pass/fail alternate each cycle.
REQ-038 ante at t0, disable_i at t1, cons at t2 -> no pulses, counters 0, busy_o low from t2.
REQ-039 CNT_W=4: 20 passes -> pass_cnt holds 15; clr_i with concurrent hit -> 0 next cycle.
